mul_arbiter: RTL

Round-robin arbiter and sequencer that shares one repeated-addition multiplier datapath (A register, down-counting B register, accumulating P register, B==0 comparator) among N_REQ requesters. It picks one requester, steers its operands onto the datapath bus, and drives the datapath load, clear and decrement strobes. It watches `eqz` until the count reaches zero, then returns the product with a one-cycle acknowledge. It sits between the requesting units and the multiplier datapath and replaces a single-user start/done controller.

---
 rtl/mul_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end for a shared repeated-addition multiplier.
// One requester at a time is granted; its operands are steered onto dbus
// (A then B), the datapath is strobed until eqz, and the product is returned
// with a one-cycle ack. Strobes, dbus, gnt, ack and busy decode the state register.
module mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_in,
  input  logic [N_REQ*W-1:0] b_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   ack,
  output logic [W-1:0]       result,
  output logic               busy,
  output logic [W-1:0]       dbus,
  output logic               LdA,
  output logic               LdB,
  output logic               LdP,
  output logic               clrP,
  output logic               decB,
  input  logic               eqz,
  input  logic [W-1:0]       p_in
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADA = 3'd1,
    S_LOADB = 3'd2,
    S_MULT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  sel_q, sel_d;
  logic [IW-1:0]  last_q, last_d;
  logic [W-1:0]   result_q, result_d;
  logic [IW-1:0]  win_s;
  logic           win_found_s;
  logic [IW:0]    rr_sum_s;
  logic [IW:0]    rr_idx_s;
  logic [N_REQ-1:0] sel_onehot_s;

  // Round-robin search starting one past the last requester served.
  always_comb begin
    win_s       = '0;
    win_found_s = 1'b0;
    rr_sum_s    = '0;
    rr_idx_s    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_sum_s = {1'b0, last_q} + (IW+1)'(k);
      rr_idx_s = (rr_sum_s >= (IW+1)'(N_REQ)) ? (rr_sum_s - (IW+1)'(N_REQ)) : rr_sum_s;
      if (!win_found_s && req[rr_idx_s[IW-1:0]]) begin
        win_s       = rr_idx_s[IW-1:0];
        win_found_s = 1'b1;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // One-hot form of the latched selection, used for gnt and ack.
  always_comb begin
    sel_onehot_s        = '0;
    sel_onehot_s[sel_q] = 1'b1;
  end

  // Next-state logic: arbitration, operand sequencing and product capture.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          sel_d   = win_s;
          state_d = S_LOADA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOADA: state_d = S_LOADB;
      S_LOADB: state_d = S_MULT;
      S_MULT: begin
        if (eqz) begin
          result_d = p_in;
          last_d   = sel_q;
          state_d  = S_DONE;
        end else begin
          state_d = S_MULT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the state register (plus eqz for the MULT strobes).
  always_comb begin
    gnt  = '0;
    ack  = '0;
    busy = 1'b0;
    dbus = '0;
    LdA  = 1'b0;
    LdB  = 1'b0;
    LdP  = 1'b0;
    clrP = 1'b0;
    decB = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOADA: begin
        gnt  = sel_onehot_s;
        busy = 1'b1;
        dbus = a_in[sel_q*W +: W];
        LdA  = 1'b1;
      end
      S_LOADB: begin
        gnt  = sel_onehot_s;
        busy = 1'b1;
        dbus = b_in[sel_q*W +: W];
        LdB  = 1'b1;
        clrP = 1'b1;
      end
      S_MULT: begin
        gnt  = sel_onehot_s;
        busy = 1'b1;
        LdP  = !eqz;
        decB = !eqz;
      end
      S_DONE: begin
        gnt  = sel_onehot_s;
        ack  = sel_onehot_s;
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // State, selection, round-robin pointer and product registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      last_q   <= IW'(N_REQ-1);
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule
